// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding a 4-digit display.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the all-ones blank code.
module bcd_digit_converter #(
  parameter int BIN_WIDTH   = 14,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [DIGIT_WIDTH-1:0] digit3,
  output logic [DIGIT_WIDTH-1:0] digit2,
  output logic [DIGIT_WIDTH-1:0] digit1,
  output logic [DIGIT_WIDTH-1:0] digit0
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [15:0]            bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [DIGIT_WIDTH-1:0] digit_q [4];
  logic [DIGIT_WIDTH-1:0] digit_d [4];

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    digit_d    = digit_q;
    bcd_adj    = bcd_q;

    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          bcd_d     = '0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d     = {bcd_adj[14:0], bin_q[BIN_WIDTH-1]};
        bin_d     = bin_q << 1;
        // Any bit leaving the 16-bit window means a fifth decimal digit exists (> 9999).
        ovf_acc_d = ovf_acc_q | bcd_adj[15];
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          overflow_d = ovf_acc_d;
          for (int unsigned i = 0; i < 4; i++) begin
            digit_d[i] = ovf_acc_d ? DIGIT_WIDTH'(4'd9) : DIGIT_WIDTH'(bcd_d[4*i +: 4]);
          end
`ifdef LEADING_ZERO_BLANK_EN
          if (!ovf_acc_d) begin : blank_leading
            logic blank;
            blank = 1'b1;
            for (int unsigned i = 3; i >= 1; i--) begin
              if (blank && bcd_d[4*i +: 4] == 4'd0) digit_d[i] = '1;
              else blank = 1'b0;
            end
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) digit_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digit_q    <= digit_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit3   = digit_q[3];
  assign digit2   = digit_q[2];
  assign digit1   = digit_q[1];
  assign digit0   = digit_q[0];

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Self-checking bench for bcd_digit_converter: random and directed values against a decimal-arithmetic model.
module tb_bcd_digit_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] bin_in = '0;
  logic        start = 1'b0;
  logic        busy, done, overflow;
  logic [7:0]  digit3, digit2, digit1, digit0;
  logic [7:0]  dig [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bcd_digit_converter #(.BIN_WIDTH(14), .DIGIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .overflow(overflow),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    dig[0] = digit0;
    dig[1] = digit1;
    dig[2] = digit2;
    dig[3] = digit3;
  end

  // Expected display digit at position pos (0 = units) for value v.
  function automatic logic [7:0] exp_digit(int v, int pos);
    int p10;
    p10 = 1;
    for (int j = 0; j < pos; j++) p10 = p10 * 10;
    if (v > 9999) return 8'd9;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && v < p10) return 8'hFF;
`endif
    return 8'((v / p10) % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and waits for done; lat counts edges after the accepting edge.
  task automatic run_conv(input int v, output int lat, output bit ok);
    bin_in = 14'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/ovf=%b required 000", {busy, done, overflow});
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dig[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_digit%0d: got %h required 00", i, dig[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    bin_in = 14'd1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_after_start: got %b required 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 14) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required 14", lat);
    end
    n_checks++;
    if ({busy, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_busy_ovf_at_done: got %b required 00", {busy, overflow});
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dig[i] !== exp_digit(1234, i)) begin
        n_fail++;
        $display("FAIL basic_digit%0d: got %h required %h", i, dig[i], exp_digit(1234, i));
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_one_cycle: got %b required 0", done);
    end
  endtask

  task automatic check_value(input int v, input string tag);
    int lat;
    bit ok;
    run_conv(v, lat, ok);
    n_checks++;
    if (!ok || lat !== 14) begin
      n_fail++;
      $display("FAIL %s_latency v=%0d: got %0d (done=%b) required 14", tag, v, lat, ok);
    end
    n_checks++;
    if (overflow !== (v > 9999)) begin
      n_fail++;
      $display("FAIL %s_overflow v=%0d: got %b required %b", tag, v, overflow, v > 9999);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dig[i] !== exp_digit(v, i)) begin
        n_fail++;
        $display("FAIL %s_digit%0d v=%0d: got %h required %h", tag, i, v, dig[i], exp_digit(v, i));
      end
    end
    tick();
  endtask

  task automatic test_boundaries();
    int vals[7] = '{0, 50, 9, 9999, 10000, 16383, 1000};
    foreach (vals[i]) check_value(vals[i], "boundary");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) check_value(int'($urandom_range(16383, 0)), "random");
  endtask

  task automatic test_ignore_start();
    int ndone, done_at;
    bin_in = 14'd42;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ndone = 0;
    done_at = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        bin_in = 14'd77;
        start  = 1'b1;
      end
      tick();
      if (c == 5) start = 1'b0;
      if (c > 5 && c < 14) bin_in = 14'($urandom_range(16383, 0));
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
    end
    n_checks++;
    if (ndone !== 1 || done_at !== 14) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d pulses first at %0d required 1 at 14", ndone, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dig[i] !== exp_digit(42, i)) begin
        n_fail++;
        $display("FAIL ignore_held_digit%0d: got %h required %h", i, dig[i], exp_digit(42, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    bin_in = 14'd4321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b required 000", {busy, done, overflow});
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dig[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL midreset_digit%0d: got %h required 00", i, dig[i]);
      end
    end
    ndone = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d pulses required 0", ndone);
    end
    check_value(4321, "after_reset");
  endtask

  task automatic test_back_to_back();
    int t_prev, waited;
    bin_in = 14'd1;
    start  = 1'b1;
    t_prev = cyc;
    tick();
    for (int v = 1; v <= 3; v++) begin
      bin_in = 14'($urandom_range(16383, 0));
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      n_checks++;
      if (done !== 1'b1 || (cyc - t_prev) !== 15) begin
        n_fail++;
        $display("FAIL b2b_spacing v=%0d: got %0d cycles (done=%b) required 15", v, cyc - t_prev, done);
      end
      t_prev = cyc;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dig[i] !== exp_digit(v, i)) begin
          n_fail++;
          $display("FAIL b2b_digit%0d v=%0d: got %h required %h", i, v, dig[i], exp_digit(v, i));
        end
      end
      bin_in = 14'(v + 1);
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 16; c++) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
